// File: rtl/fpm_32_seq.sv
// Sequential IEEE-754 single-precision multiplier: shift-add mantissa product,
// round-to-nearest-even, flush-to-zero underflow, fixed latency of MAN_W+4 cycles.
//   state  | meaning
//   IDLE   | waiting for start; captures operands and classifies specials
//   MUL    | one multiplier bit per cycle into the product accumulator
//   NORM   | picks fraction, guard and sticky from the product
//   RND    | RNE increment, exponent range check, result register load
//   DONE   | result valid, done pulse
module fpm_32_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [EXP_W+MAN_W:0]   op_a_i,
    input  logic [EXP_W+MAN_W:0]   op_b_i,
    output logic [EXP_W+MAN_W:0]   result_o,
    output logic                   done_o,
    output logic                   busy_o
);
    localparam int W   = EXP_W + MAN_W + 1;
    localparam int MW1 = MAN_W + 1;
    localparam int PW  = 2 * MW1;
    localparam int CW  = $clog2(MW1);
    localparam int XW  = EXP_W + 2;
    localparam logic signed [XW-1:0] BIAS = XW'(2**(EXP_W-1) - 1);
    localparam logic signed [XW-1:0] EMAX = XW'(2**EXP_W - 1);
    localparam logic signed [XW-1:0] ONE  = XW'(1);
    localparam logic signed [XW-1:0] ZERO = XW'(0);
    localparam logic [CW-1:0]        CNT_LAST = CW'(MAN_W);

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_NORM, S_RND, S_DONE} state_t;
    typedef enum logic [1:0] {K_NUM, K_NAN, K_INF, K_ZERO} kind_t;

    state_t                state_q, state_d;
    kind_t                 kind_q, kind_d;
    logic                  sign_q, sign_d;
    logic signed [XW-1:0]  exp_q, exp_d;
    logic [MAN_W:0]        ma_q, ma_d, mb_q, mb_d;
    logic [PW-1:0]         acc_q, acc_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [MAN_W-1:0]      frac_q, frac_d;
    logic                  guard_q, guard_d, sticky_q, sticky_d;
    logic [W-1:0]          result_q, result_d;

    logic [EXP_W-1:0]      ea, eb;
    logic [MAN_W-1:0]      fa, fb;
    logic                  a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic                  rnd_inc;
    logic [MAN_W:0]        frac_rnd;
    logic signed [XW-1:0]  exp_rnd;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            kind_q   <= K_NUM;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            ma_q     <= '0;
            mb_q     <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            frac_q   <= '0;
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            kind_q   <= kind_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            ma_q     <= ma_d;
            mb_q     <= mb_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            frac_q   <= frac_d;
            guard_q  <= guard_d;
            sticky_q <= sticky_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        kind_d   = kind_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        ma_d     = ma_q;
        mb_d     = mb_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        frac_d   = frac_q;
        guard_d  = guard_q;
        sticky_d = sticky_q;
        result_d = result_q;

        ea     = op_a_i[W-2 -: EXP_W];
        eb     = op_b_i[W-2 -: EXP_W];
        fa     = op_a_i[MAN_W-1:0];
        fb     = op_b_i[MAN_W-1:0];
        a_zero = (ea == '0);
        b_zero = (eb == '0);
        a_nan  = (&ea) && (|fa);
        b_nan  = (&eb) && (|fb);
        a_inf  = (&ea) && !(|fa);
        b_inf  = (&eb) && !(|fb);

        rnd_inc  = guard_q & (sticky_q | frac_q[0]);
        frac_rnd = {1'b0, frac_q} + {{MAN_W{1'b0}}, rnd_inc};
        exp_rnd  = frac_rnd[MAN_W] ? exp_q + ONE : exp_q;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    sign_d = op_a_i[W-1] ^ op_b_i[W-1];
                    exp_d  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
                    ma_d   = {1'b1, fa};
                    mb_d   = {1'b1, fb};
                    acc_d  = '0;
                    cnt_d  = '0;
                    // Subnormals count as zero, so inf*subnormal is also NaN.
                    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
                        kind_d = K_NAN;
                    else if (a_inf || b_inf)
                        kind_d = K_INF;
                    else if (a_zero || b_zero)
                        kind_d = K_ZERO;
                    else
                        kind_d = K_NUM;
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                if (mb_q[0])
                    acc_d = acc_q + ({{MW1{1'b0}}, ma_q} << cnt_q);
                mb_d  = mb_q >> 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST)
                    state_d = S_NORM;
            end
            S_NORM: begin
                if (acc_q[PW-1]) begin
                    exp_d    = exp_q + ONE;
                    frac_d   = acc_q[PW-2 -: MAN_W];
                    guard_d  = acc_q[PW-2-MAN_W];
                    sticky_d = |acc_q[PW-3-MAN_W:0];
                end else begin
                    frac_d   = acc_q[PW-3 -: MAN_W];
                    guard_d  = acc_q[PW-3-MAN_W];
                    sticky_d = |acc_q[PW-4-MAN_W:0];
                end
                state_d = S_RND;
            end
            S_RND: begin
                unique case (kind_q)
                    K_NAN:  result_d = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
                    K_INF:  result_d = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    K_ZERO: result_d = {sign_q, {(W-1){1'b0}}};
                    default: begin
                        if (exp_rnd >= EMAX)
                            result_d = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        else if (exp_rnd <= ZERO)
                            result_d = {sign_q, {(W-1){1'b0}}};
                        else
                            result_d = {sign_q, exp_rnd[EXP_W-1:0], frac_rnd[MAN_W-1:0]};
                    end
                endcase
                state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign result_o = result_q;
    assign done_o   = (state_q == S_DONE);
    assign busy_o   = (state_q != S_IDLE);
endmodule

// File: tb/tb_fpm_32_seq.sv
// Scoreboard bench for fpm_32_seq: expected products queued at start, popped on done.
module tb_fpm_32_seq;
    logic        clk = 1'b0;
    logic        rst, start, done, busy;
    logic [31:0] op_a, op_b, result;
    logic [31:0] sb[$];
    int          n_chk = 0, n_pass = 0, n_done = 0;

    fpm_32_seq dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .op_a_i  (op_a),
        .op_b_i  (op_b),
        .result_o(result),
        .done_o  (done),
        .busy_o  (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        n_chk++;
        if (got === exp_v) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp_v);
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) begin
            n_done++;
            if (sb.size() == 0) chk("spurious_done", {31'b0, done}, 32'h0);
            else                chk("result", result, sb.pop_front());
        end
    end

    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic        s, g, st;
        logic [7:0]  ea, eb;
        logic [22:0] fa, fb;
        logic [47:0] p;
        logic [23:0] m;
        int          e;
        s = a[31] ^ b[31];
        ea = a[30:23]; eb = b[30:23];
        fa = a[22:0];  fb = b[22:0];
        if ((ea == 8'hFF && fa != 0) || (eb == 8'hFF && fb != 0) ||
            (ea == 8'hFF && eb == 0) || (eb == 8'hFF && ea == 0))
            return 32'h7FC00000;
        if (ea == 8'hFF || eb == 8'hFF) return {s, 8'hFF, 23'h0};
        if (ea == 0 || eb == 0) return {s, 31'h0};
        p = 48'({1'b1, fa}) * 48'({1'b1, fb});
        e = int'(ea) + int'(eb) - 127;
        if (p[47]) begin
            e++;
            m = {1'b0, p[46:24]}; g = p[23]; st = |p[22:0];
        end else begin
            m = {1'b0, p[45:23]}; g = p[22]; st = |p[21:0];
        end
        if (g && (st || m[0])) m = m + 24'd1;
        if (m[23]) begin
            e++;
            m = '0;
        end
        if (e >= 255) return {s, 8'hFF, 23'h0};
        if (e <= 0) return {s, 31'h0};
        return {s, e[7:0], m[22:0]};
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_v);
        int lat;
        @(negedge clk);
        op_a = a; op_b = b; start = 1'b1;
        sb.push_back(exp_v);
        @(negedge clk);
        start = 1'b0;
        op_a = $urandom; op_b = $urandom;
        lat = 1;
        chk("busy_after_start", {31'b0, busy}, 32'h1);
        while (done !== 1'b1 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 32'd27);
        @(negedge clk);
        chk("busy_after_done", {31'b0, busy}, 32'h0);
        chk("result_hold", result, exp_v);
    endtask

    logic [31:0] va[9], vb[9], ve[9];
    logic [31:0] ra, rb;
    int          d0;

    initial begin
        va = '{32'h42B6B000, 32'h3F800000, 32'hBF800000, 32'h3F800001, 32'h3FFFFFFF,
               32'h7F7FFFFF, 32'h00800000, 32'h7F800000, 32'h7FC00000};
        vb = '{32'h3E140000, 32'h40000000, 32'h40000000, 32'h3F800001, 32'h3FFFFFFF,
               32'h40000000, 32'h3F000000, 32'h00000000, 32'h3F800000};
        ve = '{32'h41533B80, 32'h40000000, 32'hC0000000, 32'h3F800002, 32'h407FFFFE,
               32'h7F800000, 32'h00000000, 32'h7FC00000, 32'h7FC00000};

        rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0;
        #12;
        chk("reset_result", result, 32'h0);
        chk("reset_done", {31'b0, done}, 32'h0);
        chk("reset_busy", {31'b0, busy}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) run_op(va[i], vb[i], ve[i]);

        run_op(32'hFF800000, 32'h40400000, 32'hFF800000);
        run_op(32'h80000000, 32'h3F800000, 32'h80000000);
        run_op(32'h007FFFFF, 32'h7F000000, 32'h00000000);

        for (int i = 0; i < 12; i++) begin
            ra = {1'($urandom_range(0, 1)), 8'($urandom_range(60, 190)), 23'($urandom)};
            rb = {1'($urandom_range(0, 1)), 8'($urandom_range(60, 190)), 23'($urandom)};
            run_op(ra, rb, ref_mul(ra, rb));
        end

        // Reset in the middle of the multiply loop.
        @(negedge clk);
        op_a = 32'h40400000; op_b = 32'h40400000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_done", {31'b0, done}, 32'h0);
        chk("rst_result", result, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        d0 = n_done;
        repeat (40) @(negedge clk);
        chk("rst_no_done", 32'(n_done - d0), 32'h0);
        run_op(32'h40400000, 32'h40400000, 32'h41100000);

        // start held high through the busy window.
        @(negedge clk);
        op_a = 32'h40A00000; op_b = 32'hC0000000; start = 1'b1;
        sb.push_back(32'hC1200000);
        d0 = n_done;
        repeat (25) @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        chk("held_start_one_done", 32'(n_done - d0), 32'h1);
        chk("sb_drained", 32'(sb.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
